// File: rtl/int_request_ctrl_pkg.sv
// Shared types and default constants for the interrupt request controller.
package int_request_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StReq   = 2'd1,
      StServe = 2'd2
   } state_e;

   localparam int unsigned NumSrcDefault    = 4;
   localparam logic [31:0] VecBaseDefault   = 32'h0000_0100;
   localparam logic [31:0] VecStrideDefault = 32'h0000_0010;

endpackage

// File: rtl/int_request_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder over the eligible source vector.
module int_request_ctrl_prio_enc #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic [NUM_SRC-1:0] eligible_i,
   output logic               valid_o,
   output logic [ID_W-1:0]    id_o
);

   always_comb begin
      valid_o = |eligible_i;
      id_o    = '0;
      // Scan downward so the lowest set index is the last assignment.
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible_i[i]) id_o = ID_W'(i);
      end
   end

endmodule

// File: rtl/int_request_ctrl.sv
// Device-side vectored interrupt request controller with ack/EOI handshake.
// Optional ack timeout in REQ is enabled by defining INT_REQ_TIMEOUT_EN.
import int_request_ctrl_pkg::*;

module int_request_ctrl #(
   parameter int unsigned NUM_SRC    = NumSrcDefault,
   parameter logic [31:0] VEC_BASE   = VecBaseDefault,
   parameter logic [31:0] VEC_STRIDE = VecStrideDefault
`ifdef INT_REQ_TIMEOUT_EN
   ,
   parameter int unsigned ACK_TIMEOUT = 16
`endif
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] done_i,
   input  logic               mask_we_i,
   input  logic [NUM_SRC-1:0] mask_wd_i,
   input  logic               int_ack_i,
   input  logic               eoi_i,
   output logic               interrupt_o,
   output logic [31:0]        int_addr_o,
   output logic [NUM_SRC-1:0] pending_o,
   output logic               busy_o
);

   localparam int unsigned IdW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   state_e             state_q, state_d;
   logic [NUM_SRC-1:0] done_q;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] mask_q, mask_d;
   logic [NUM_SRC-1:0] clr;
   logic [NUM_SRC-1:0] edge_det;
   logic [IdW-1:0]     cur_id_q, cur_id_d;
   logic [31:0]        addr_q, addr_d;
   logic               irq_q, irq_d;
   logic               win_valid;
   logic [IdW-1:0]     win_id;

`ifdef INT_REQ_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
   logic        timeout;

   assign timeout = (cnt_q == 16'(ACK_TIMEOUT - 1));
   // Zero outside REQ, so the count restarts on every entry into REQ.
   assign cnt_d   = (state_q == StReq) ? cnt_q + 16'd1 : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`endif

   assign edge_det = done_i & ~done_q;

   int_request_ctrl_prio_enc #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (IdW)
   ) u_prio_enc (
      .eligible_i (pending_q & mask_q),
      .valid_o    (win_valid),
      .id_o       (win_id)
   );

   always_comb begin
      state_d  = state_q;
      cur_id_d = cur_id_q;
      addr_d   = addr_q;
      irq_d    = irq_q;
      clr      = '0;
      unique case (state_q)
         StIdle: begin
            if (win_valid) begin
               state_d  = StReq;
               cur_id_d = win_id;
               addr_d   = VEC_BASE + 32'(win_id) * VEC_STRIDE;
               irq_d    = 1'b1;
            end
         end
         StReq: begin
            if (int_ack_i) begin
               state_d       = StServe;
               irq_d         = 1'b0;
               clr[cur_id_q] = 1'b1;
`ifdef INT_REQ_TIMEOUT_EN
            end else if (timeout) begin
               // Withdraw but keep pending so IDLE re-arbitrates next cycle.
               state_d = StIdle;
               irq_d   = 1'b0;
`endif
            end
         end
         StServe: begin
            if (eoi_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // A new edge on the served source outranks its clear.
   assign pending_d = (pending_q & ~clr) | edge_det;
   assign mask_d    = mask_we_i ? mask_wd_i : mask_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         done_q    <= '0;
         pending_q <= '0;
         mask_q    <= '1;
         cur_id_q  <= '0;
         addr_q    <= '0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         done_q    <= done_i;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         cur_id_q  <= cur_id_d;
         addr_q    <= addr_d;
         irq_q     <= irq_d;
      end
   end

   assign interrupt_o = irq_q;
   assign int_addr_o  = addr_q;
   assign pending_o   = pending_q;
   assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_int_request_ctrl.sv
// Directed plus randomized bench for int_request_ctrl against a behavioural model.
module tb_int_request_ctrl;

   localparam int AckTimeout = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  done;
   logic        mask_we;
   logic [3:0]  mask_wd;
   logic        int_ack;
   logic        eoi;
   logic        interrupt;
   logic [31:0] int_addr;
   logic [3:0]  pending;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: phase 0 idle, 1 requesting, 2 in handler.
   int          m_phase;
   int          m_id;
   int          m_age;
   bit [3:0]    m_pend;
   bit [3:0]    m_mask;
   bit [3:0]    m_doneq;
   bit          m_irq;
   bit [31:0]   m_addr;

   always #5 clk = ~clk;

   int_request_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .done_i      (done),
      .mask_we_i   (mask_we),
      .mask_wd_i   (mask_wd),
      .int_ack_i   (int_ack),
      .eoi_i       (eoi),
      .interrupt_o (interrupt),
      .int_addr_o  (int_addr),
      .pending_o   (pending),
      .busy_o      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_id = 0; m_age = 0;
      m_pend = '0; m_mask = 4'hf; m_doneq = '0; m_irq = 0; m_addr = '0;
   endtask

   task automatic model_clock(input bit [3:0] dn, input bit we, input bit [3:0] wd,
                              input bit ack, input bit e);
      bit [3:0] nxt;
      int       win;
      nxt = m_pend;
      win = -1;
      for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i]) win = i;
      if (m_phase == 0) begin
         if (win >= 0) begin
            m_phase = 1; m_id = win; m_irq = 1; m_age = 0;
            m_addr = 32'h100 + 32'(win) * 32'h10;
         end
      end else if (m_phase == 1) begin
         if (ack) begin
            m_phase = 2; m_irq = 0; nxt[m_id] = 1'b0;
         end else begin
            m_age++;
`ifdef INT_REQ_TIMEOUT_EN
            if (m_age == AckTimeout) begin
               m_phase = 0; m_irq = 0;
            end
`endif
         end
      end else if (e) begin
         m_phase = 0;
      end
      nxt = nxt | (dn & ~m_doneq);
      if (we) m_mask = wd;
      m_doneq = dn;
      m_pend  = nxt;
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".interrupt"}, {31'd0, interrupt}, {31'd0, m_irq});
      check({tag, ".int_addr"}, int_addr, m_addr);
      check({tag, ".pending"}, {28'd0, pending}, {28'd0, m_pend});
      check({tag, ".busy"}, {31'd0, busy}, {31'd0, m_phase != 0});
   endtask

   task automatic step(input logic [3:0] dn, input logic we, input logic [3:0] wd,
                       input logic ack, input logic e);
      done = dn; mask_we = we; mask_wd = wd; int_ack = ack; eoi = e;
      @(posedge clk);
      model_clock(dn, we, wd, ack, e);
      #1;
      compare_all("model");
   endtask

   task automatic idle(input logic [3:0] dn, input int n);
      for (int i = 0; i < n; i++) step(dn, 1'b0, 4'h0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; done = '0; mask_we = 0; mask_wd = '0; int_ack = 0; eoi = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all("reset");
      reset = 1'b0;

      // Single source 2.
      idle(4'h0, 4);
      step(4'b0100, 0, 0, 0, 0);
      check("single.pend", {28'd0, pending}, 32'h4);
      step(4'b0100, 0, 0, 0, 0);
      check("single.irq", {31'd0, interrupt}, 32'h1);
      check("single.addr", int_addr, 32'h120);
      idle(4'b0100, 2);
      step(4'b0100, 0, 0, 1, 0);
      check("single.ack_pend", {28'd0, pending}, 32'h0);
      idle(4'b0100, 2);
      step(4'b0100, 0, 0, 0, 1);
      check("single.eoi_busy", {31'd0, busy}, 32'h0);
      idle(4'h0, 1);

      // Fixed priority, then back-to-back request.
      step(4'b1010, 0, 0, 0, 0);
      step(4'b1010, 0, 0, 0, 0);
      check("prio.first", int_addr, 32'h110);
      step(4'b1010, 0, 0, 1, 0);
      step(4'b1010, 0, 0, 0, 1);
      step(4'b1010, 0, 0, 0, 0);
      check("prio.second", int_addr, 32'h130);
      step(4'b1010, 0, 0, 1, 0);
      step(4'b0000, 0, 0, 0, 1);

      // No preemption while requesting.
      step(4'b1000, 0, 0, 0, 0);
      step(4'b1000, 0, 0, 0, 0);
      step(4'b1001, 0, 0, 0, 0);
      step(4'b1001, 0, 0, 0, 0);
      check("nopre.hold", int_addr, 32'h130);
      step(4'b1001, 0, 0, 1, 0);
      step(4'b1001, 0, 0, 0, 1);
      step(4'b1001, 0, 0, 0, 0);
      check("nopre.next", int_addr, 32'h100);
      step(4'b1001, 0, 0, 1, 0);
      step(4'b0000, 0, 0, 0, 1);

      // Masked source accumulates but is not requested.
      step(4'b0000, 1, 4'b1110, 0, 0);
      step(4'b0001, 0, 0, 0, 0);
      check("mask.pend", {28'd0, pending}, 32'h1);
      step(4'b0001, 0, 0, 0, 0);
      check("mask.noirq", {31'd0, interrupt}, 32'h0);
      step(4'b0001, 1, 4'b1111, 0, 0);
      step(4'b0001, 0, 0, 0, 0);
      check("mask.irq", {31'd0, interrupt}, 32'h1);
      check("mask.addr", int_addr, 32'h100);
      step(4'b0001, 0, 0, 1, 0);
      step(4'b0000, 0, 0, 0, 1);

      // New edge in the ack cycle keeps the bit set.
      step(4'b0010, 0, 0, 0, 0);
      step(4'b0010, 0, 0, 0, 0);
      step(4'b0000, 0, 0, 0, 0);
      step(4'b0010, 0, 0, 1, 0);
      check("setwins.pend", {28'd0, pending}, 32'h2);
      step(4'b0010, 0, 0, 0, 1);
      step(4'b0010, 0, 0, 0, 0);
      check("setwins.rereq", int_addr, 32'h110);
      step(4'b0010, 0, 0, 1, 0);
      step(4'b0000, 1, 4'b0000, 0, 0);

      // Asynchronous reset while in SERVE.
      #2 reset = 1'b1;
      #1;
      model_reset();
      compare_all("async_reset");
      @(posedge clk);
      #1 reset = 1'b0;
      step(4'b1000, 0, 0, 0, 0);
      step(4'b1000, 0, 0, 0, 0);
      check("reset.mask_ones", int_addr, 32'h130);
      step(4'b1000, 0, 0, 1, 0);
      step(4'b0000, 0, 0, 0, 1);

`ifdef INT_REQ_TIMEOUT_EN
      step(4'b0100, 0, 0, 0, 0);
      step(4'b0100, 0, 0, 0, 0);
      idle(4'b0100, AckTimeout - 1);
      check("tmo.still_req", {31'd0, interrupt}, 32'h1);
      step(4'b0100, 0, 0, 0, 0);
      check("tmo.drop", {31'd0, interrupt}, 32'h0);
      check("tmo.pend_kept", {28'd0, pending}, 32'h4);
      step(4'b0100, 0, 0, 0, 0);
      check("tmo.reassert", {31'd0, interrupt}, 32'h1);
      step(4'b0100, 0, 0, 1, 0);
      step(4'b0000, 0, 0, 0, 1);
`endif

      // Randomized traffic against the model.
      for (int c = 0; c < 600; c++) begin
         logic [3:0] dn;
         logic       we;
         dn = ($urandom_range(0, 2) == 0) ? 4'($urandom) : done;
         we = ($urandom_range(0, 19) == 0);
         step(dn, we, 4'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/int_request_ctrl.md
Name: int_request_ctrl

Overview:
Device-side interrupt source controller for the single-cycle MIPS core's vectored interrupt.
- Captures completion events (done[3:0]) from up to four peripherals and prioritises them.
- Drives a single interrupt request with a vector address (int_addr) toward the core's interrupt encoder.
- Completes the handshake on int_ack and holds off further requests until the handler signals end-of-interrupt (eoi).

Parameters:
NUM_SRC, 4, number of interrupt sources; fixed priority, index 0 highest.
VEC_BASE, 32'h0000_0100, vector address of source 0.
VEC_STRIDE, 32'h0000_0010, byte distance between consecutive source vectors.
ACK_TIMEOUT, 16, cycles to wait for int_ack before withdrawing a request (used only with the optional feature).

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  asynchronous, active-high.
done  in  NUM_SRC  per-source completion level; a rising edge is one event.
mask_we  in  1  mask register write strobe.
mask_wd  in  NUM_SRC  mask write data; 1 = source enabled.
int_ack  in  1  acknowledge from core (level).
eoi  in  1  end-of-interrupt pulse from core (status_write path).
interrupt  out  1  registered interrupt request to core.
int_addr  out  32  registered vector address of the source being requested or served.
pending  out  NUM_SRC  current pending bits (diagnostic/display).
busy  out  1  high in REQ or SERVE.

Behaviour:
Reset values:
- State IDLE; pending=0; mask=all ones; interrupt=0; int_addr=0; busy=0; done_q=0; cur_id=0.

Event capture:
- edge[i] = done[i] & ~done_q[i]; done_q <= done every cycle.
- pending[i] is set at the posedge where edge[i]=1, regardless of mask or state.
- Clear has lower priority than set: if the served source's bit is cleared in the same cycle a new edge arrives, the bit stays 1.

Mask:
- On mask_we, mask <= mask_wd at posedge.
- Masked sources still accumulate pending; they are only excluded from arbitration.

Arbitration:
- eligible = pending & mask; winner = lowest set index.

FSM:
- IDLE: if eligible != 0, go to REQ at next posedge; cur_id <= winner; int_addr <= VEC_BASE + winner*VEC_STRIDE (32-bit, wrap ignored); interrupt <= 1.
- REQ: hold interrupt, int_addr and cur_id stable (no re-arbitration even if a higher-priority source arrives). If int_ack=1 at posedge: go to SERVE; interrupt <= 0; pending[cur_id] <= 0 (subject to the set-wins rule).
- SERVE: interrupt=0; int_addr is held. On eoi=1 go to IDLE. Further pending sources wait.
- eoi in IDLE or REQ: ignored.
- int_ack in IDLE or SERVE: ignored.

Latency:
- Edge sampled at posedge k sets pending at k; interrupt is high after posedge k+1 (one cycle).
- Back-to-back: eoi at posedge m with other eligible sources gives IDLE at m; the new request is high after m+1.

Other rules:
- Reset asserted mid-operation returns to the reset values immediately; captured events are lost.
- busy = (state != IDLE).

Optional Feature:
INT_REQ_TIMEOUT_EN
- Defined: an 8..16-bit counter runs in REQ. If int_ack has not arrived after ACK_TIMEOUT cycles, return to IDLE with interrupt <= 0 and pending[cur_id] kept set. Re-arbitration then happens on the next cycle, so a higher-priority source can win. Counter clears on entering REQ.
- Undefined: REQ waits indefinitely; no counter is synthesised.

Decomposition:
- Shared package: state enum (IDLE, REQ, SERVE), default VEC_BASE/VEC_STRIDE constants, NUM_SRC default.
- One natural sub-module, prio_enc: combinational lowest-index priority encoder, inputs eligible[NUM_SRC], outputs valid and id[$clog2(NUM_SRC)].

Test Plan:
- Single source: done[2] rises at cycle 5 -> pending=4'b0100 after cycle 5, interrupt=1 and int_addr=32'h120 after cycle 6; int_ack at cycle 9 -> interrupt=0, pending=0; eoi at cycle 12 -> busy=0.
- Priority: done[3] and done[1] rise in the same cycle -> int_addr=32'h110 first; after ack+eoi a second request with int_addr=32'h130.
- No preemption: done[3] served in REQ, done[0] arrives before ack -> int_addr stays 32'h130; 32'h100 is requested only after eoi.
- Mask: mask_wd=4'b1110, done[0] rises -> pending[0]=1, interrupt stays 0; then mask_wd=4'b1111 -> interrupt=1, int_addr=32'h100 one cycle later.
- Set-wins: done[1] re-rises in the ack cycle of source 1 -> pending[1]=1 after ack, re-requested after eoi. Also assert reset during SERVE -> all outputs 0 and mask=4'b1111 immediately.
- INT_REQ_TIMEOUT_EN, ACK_TIMEOUT=16: no int_ack -> interrupt drops after 16 cycles in REQ, pending bit still 1, request reasserted next cycle.
